// File: rtl/ysyx_25040105_ifu.sv
`timescale 1ns/1ps
// ysyx_25040105_ifu: instruction fetch unit; owns the PC, fetches words from imem, hands them to the IDU.
// Ports:
//   i_clk, i_rst_n                      clock, synchronous active-low reset
//   o_imem_req_valid/i_imem_req_ready   fetch request handshake, o_imem_req_addr = pc
//   i_imem_resp_valid/_data/_err        fetch response (never back-pressured)
//   o_inst_valid/i_inst_ready           instruction handshake toward IDU, o_inst/o_inst_pc payload
//   i_redirect_valid/i_redirect_pc      one-cycle PC redirect from EXU
//   o_fetch_err                         sticky fault flag, fetch halted until reset
module ysyx_25040105_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    input  logic        i_imem_resp_err,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fetch_err
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt, r_inst, w_inst_nxt, r_inst_pc, w_inst_pc_nxt;
    logic        r_flush, w_flush_nxt, w_hs, w_redir;
    assign w_hs    = (r_state == S_REQ) && i_imem_req_ready;
    assign w_redir = i_redirect_valid && (r_state != S_ERR);
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_flush_nxt   = r_flush;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        case (r_state)
            S_REQ:  if (i_imem_req_ready) w_state_nxt = S_WAIT;
            S_WAIT: if (i_imem_resp_valid) begin
                if (r_flush) begin
                    w_flush_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (i_imem_resp_err) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_inst_nxt    = i_imem_resp_data;
                    w_inst_pc_nxt = r_pc;
                    w_state_nxt   = S_HOLD;
                end
            end
            S_HOLD: if (i_inst_ready) begin
                w_pc_nxt    = r_pc + PC_STEP;
                w_state_nxt = S_REQ;
            end
            default: ;
        endcase
        // A redirect overrides every sequential decision above. If a fetch is
        // (or just became) outstanding, its response must be swallowed via flush.
        if (w_redir) begin
            if (i_redirect_pc[1:0] != 2'b00) begin
                w_pc_nxt    = r_pc;
                w_state_nxt = S_ERR;
            end else begin
                w_pc_nxt    = i_redirect_pc;
                w_flush_nxt = 1'b0;
                w_state_nxt = S_REQ;
                if (w_hs || (r_state == S_WAIT && !i_imem_resp_valid)) begin
                    w_flush_nxt = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_flush   <= 1'b0;
            r_inst    <= 32'h0;
            r_inst_pc <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_flush   <= w_flush_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
        end
    end
    assign o_imem_req_valid = (r_state == S_REQ);
    assign o_imem_req_addr  = r_pc;
    assign o_inst_valid     = (r_state == S_HOLD);
    assign o_inst           = r_inst;
    assign o_inst_pc        = r_inst_pc;
    assign o_fetch_err      = (r_state == S_ERR);
endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
`timescale 1ns/1ps
// tb_ysyx_25040105_ifu: directed + random bench for the fetch unit against a transaction-level PC/imem model.
module tb_ysyx_25040105_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    logic        clk = 0, rst_n = 0, req_ready = 0, resp_valid = 0, resp_err = 0;
    logic        inst_ready = 0, redirect_valid = 0;
    logic [31:0] resp_data = 0, redirect_pc = 0;
    logic        req_valid, inst_valid, fetch_err;
    logic [31:0] req_addr, inst, inst_pc;
    int          n_assert = 0, n_fail = 0, n_cons = 0, n0 = 0, lat = 1, p_cnt = 0;
    logic [31:0] m_pc = RST_PC, p_addr = 0, err_addr = 32'h1, h_inst = 0, h_pc = 0;
    logic        m_err = 0, p_valid = 0, p_stale = 0;

    always #5 clk = ~clk;

    ysyx_25040105_ifu dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
        .i_imem_resp_valid(resp_valid), .i_imem_resp_data(resp_data), .i_imem_resp_err(resp_err),
        .o_inst_valid(inst_valid), .i_inst_ready(inst_ready), .o_inst(inst), .o_inst_pc(inst_pc),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc), .o_fetch_err(fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive imem response, check outputs against the model, advance the model at the edge.
    task automatic cycle();
        logic hs, cons, rsp, e0;
        logic [31:0] a;
        resp_valid = p_valid && p_cnt == 0;
        resp_data  = resp_valid ? mem_word(p_addr) : $urandom;
        resp_err   = resp_valid && p_addr == err_addr;
        if (rst_n) begin
            chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
            if (m_err) chk("err_quiet", {30'b0, req_valid, inst_valid}, 32'h0);
            if (inst_valid) begin
                chk("inst_pc", inst_pc, m_pc);
                chk("inst_word", inst, mem_word(inst_pc));
            end
            if (req_valid) chk("req_addr", req_addr, m_pc);
            if (req_valid && req_ready) chk("one_in_flight", {31'b0, p_valid}, 32'h0);
        end
        hs   = req_valid && req_ready && rst_n;
        cons = inst_valid && inst_ready && rst_n;
        rsp  = resp_valid;
        a    = req_addr;
        e0   = m_err;
        @(posedge clk);
        if (rsp) p_valid = 0;
        else if (p_valid) p_cnt--;
        if (!rst_n) begin
            m_pc    = RST_PC;
            m_err   = 0;
            p_stale = 1;
        end else begin
            if (rsp && resp_err && !p_stale && !redirect_valid) m_err = 1;
            if (cons) begin
                n_cons++;
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid && !e0) begin
                if (redirect_pc[1:0] != 2'b00) m_err = 1;
                else begin
                    m_pc    = redirect_pc;
                    p_stale = 1;
                end
            end
            if (hs) begin
                p_valid = 1;
                p_addr  = a;
                p_cnt   = lat - 1;
                p_stale = redirect_valid;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic cond(input int which);
        return which == 0 ? inst_valid : which == 1 ? req_valid : !p_valid;
    endfunction

    task automatic wait_for(input int which, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (cond(which)) break;
            cycle();
        end
        chk(tag, {31'b0, cond(which)}, 32'h1);
    endtask

    task automatic do_reset();
        req_ready = 0;
        redirect_valid = 0;
        wait_for(2, 10, "drain");
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_req_valid", {31'b0, req_valid}, 32'h1);
        chk("rst_req_addr", req_addr, RST_PC);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
        req_ready = 1; inst_ready = 1; lat = 1;
        for (int k = 0; k < 9; k++) begin
            chk("seq_inst_valid", {31'b0, inst_valid}, {31'b0, k % 3 == 2});
            if (k % 3 == 2) chk("seq_inst_pc", inst_pc, RST_PC + 32'(4 * (k / 3)));
            chk("seq_req_valid", {31'b0, req_valid}, {31'b0, k % 3 == 0});
            if (k % 3 == 0) chk("seq_req_addr", req_addr, RST_PC + 32'(4 * (k / 3)));
            cycle();
        end
        inst_ready = 0;
        wait_for(0, 10, "stall_wait");
        h_inst = inst; h_pc = inst_pc;
        repeat (5) begin
            cycle();
            chk("stall_inst", inst, h_inst);
            chk("stall_pc", inst_pc, h_pc);
            chk("stall_valid", {31'b0, inst_valid}, 32'h1);
            chk("stall_no_req", {31'b0, req_valid}, 32'h0);
        end
        inst_ready = 1;
        cycle();
        chk("post_stall_req", {31'b0, req_valid}, 32'h1);
        chk("post_stall_addr", req_addr, h_pc + 32'd4);
        lat = 3;
        cycle();
        chk("in_wait", {30'b0, req_valid, inst_valid}, 32'h0);
        redirect_valid = 1; redirect_pc = 32'h8000_0100;
        cycle();
        redirect_valid = 0;
        wait_for(1, 10, "redir_wait_req");
        chk("redir_wait_addr", req_addr, 32'h8000_0100);
        lat = 1;
        wait_for(0, 10, "hold_wait");
        n0 = n_cons;
        redirect_valid = 1; redirect_pc = 32'h8000_0200;
        cycle();
        redirect_valid = 0;
        chk("hold_redir_once", n_cons, n0 + 1);
        chk("hold_redir_drop", {31'b0, inst_valid}, 32'h0);
        chk("hold_redir_req", {31'b0, req_valid}, 32'h1);
        chk("hold_redir_addr", req_addr, 32'h8000_0200);
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 0;
        wait_for(0, 20, "wrap_wait");
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_req", {31'b0, req_valid}, 32'h1);
        chk("wrap_addr", req_addr, 32'h0);
        n0 = n_cons;
        for (int i = 0; i < 400; i++) begin
            req_ready      = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 3) != 0;
            lat            = $urandom_range(3, 1);
            redirect_valid = ($urandom % 12) == 0;
            redirect_pc    = ($urandom % 2) != 0 ? RST_PC + 32'($urandom % 64) * 4
                                                 : 32'hFFFF_FFF0 + 32'($urandom % 4) * 4;
            cycle();
        end
        redirect_valid = 0;
        chk("rand_progress", {31'b0, n_cons > n0 + 20}, 32'h1);
        inst_ready = 1;
        do_reset();
        err_addr = 32'h8000_0008; req_ready = 1; lat = 1;
        repeat (12) cycle();
        chk("err_flag", {31'b0, fetch_err}, 32'h1);
        chk("err_no_req", {31'b0, req_valid}, 32'h0);
        chk("err_no_inst", {31'b0, inst_valid}, 32'h0);
        redirect_valid = 1; redirect_pc = RST_PC;
        cycle();
        redirect_valid = 0;
        cycle();
        chk("err_sticky", {31'b0, fetch_err}, 32'h1);
        chk("err_sticky_req", {31'b0, req_valid}, 32'h0);
        err_addr = 32'h1;
        do_reset();
        req_ready = 1;
        repeat (4) cycle();
        redirect_valid = 1; redirect_pc = 32'h8000_0102;
        cycle();
        redirect_valid = 0;
        chk("misalign_err", {31'b0, fetch_err}, 32'h1);
        chk("misalign_no_req", {31'b0, req_valid}, 32'h0);
        do_reset();
        req_ready = 1; lat = 3;
        cycle();
        chk("rw_in_wait", {31'b0, req_valid}, 32'h0);
        rst_n = 0; req_ready = 0;
        cycle();
        rst_n = 1;
        chk("rw_req", {31'b0, req_valid}, 32'h1);
        chk("rw_addr", req_addr, RST_PC);
        chk("rw_inst_valid", {31'b0, inst_valid}, 32'h0);
        wait_for(2, 10, "rw_late_resp");
        chk("rw_dropped", {31'b0, inst_valid}, 32'h0);
        req_ready = 1; lat = 1;
        wait_for(0, 10, "rw_refetch");
        chk("rw_pc", inst_pc, RST_PC);
        chk("rw_inst", inst, mem_word(RST_PC));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
